pipe_mem_stage: RTL and testbench
=================================

Name: pipe_mem_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the pipelined CPU.
- Consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn) and performs the data-memory load or store over a req/ack bus.
- Stalls the upstream pipeline while a bus access is outstanding.
- Registers the results toward WB (wwreg, wm2reg, wmo, walu, wrn).

Parameters:
- TIMEOUT, 15: maximum wait cycles in BUSY before the bus access is abandoned as an error. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge
- clrn  in  1  asynchronous active-low reset
- mwreg  in  1  register-write enable from EX/MEM
- mm2reg  in  1  load (result from memory) from EX/MEM
- mwmem  in  1  store enable from EX/MEM
- malu  in  32  ALU result / memory address
- mb  in  32  store data
- mrn  in  5  destination register number
- d_req  out  1  bus request
- d_we  out  1  bus write enable
- d_addr  out  32  bus address
- d_wdata  out  32  bus write data
- d_ack  in  1  bus acknowledge, single-cycle pulse
- d_rdata  in  32  bus read data, valid when d_ack=1
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- bus_err  out  1  registered one-cycle pulse on timeout
- wwreg  out  1  MEM/WB register-write enable
- wm2reg  out  1  MEM/WB load select
- wmo  out  32  MEM/WB memory data
- walu  out  32  MEM/WB ALU result
- wrn  out  5  MEM/WB destination register

Behaviour:
- access = mm2reg | mwmem. If both are 1, treat as a store (d_we=1); wm2reg is still passed through.
- FSM states IDLE and BUSY; a wait counter cnt of width ceil(log2(TIMEOUT+1)).
- d_addr = malu, d_wdata = mb and d_we = mwmem, driven combinationally whenever d_req=1. When d_req=0 they are 0.
- d_req = access in both IDLE and BUSY.
- IDLE:
  - access=0: no request, mem_stall=0, MEM/WB captures inputs (wmo=0).
  - access=1 and d_ack=1 (zero-wait): mem_stall=0, MEM/WB captures inputs with wmo=d_rdata for a load (0 for a store), FSM stays IDLE.
  - access=1 and d_ack=0: mem_stall=1, MEM/WB loads a bubble (wwreg=0, wm2reg=0, others 0), next state BUSY, cnt=1.
- BUSY:
  - EX/MEM is frozen by mem_stall, so the inputs are stable.
  - d_ack=1: mem_stall=0, MEM/WB captures as in the zero-wait case, next state IDLE, cnt=0.
  - d_ack=0 and cnt<TIMEOUT: mem_stall=1, bubble, cnt+1.
  - d_ack=0 and cnt==TIMEOUT: mem_stall=0, MEM/WB captures with wmo=0 and wwreg forced 0, bus_err=1 next cycle, next state IDLE.
- Latency: 1 cycle from MEM input to W outputs for zero-wait and non-memory ops; 1+N cycles for N wait states.
- Stores: wwreg = mwreg, unchanged by the store itself.
- d_ack in IDLE with access=0 is ignored.
- Reset (clrn=0, any time including mid-BUSY):
  - state IDLE, cnt 0.
  - wwreg, wm2reg, wmo, walu, wrn and bus_err all 0.
  - d_req 0 and mem_stall 0 combinationally while clrn=0.
- All registers update only on the rising clk edge when clrn=1.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port mexc (1 bit) and behaviour for an access with malu[1:0]!=0.
  - No bus request is issued, mem_stall=0, and MEM/WB captures a bubble.
  - mexc is a registered one-cycle pulse the next cycle, for the interrupt logic.
  - mexc resets to 0.
- Not defined:
  - No mexc port.
  - Low address bits are passed to d_addr unchanged and the access proceeds normally.

Test Plan:
1. Reset mid-BUSY:
   - Stimulus: load issued, d_ack held 0 for 2 cycles, then clrn=0.
   - Required: all W outputs 0, d_req=0, mem_stall=0, and after release the FSM is IDLE with no request.
2. Zero-wait load:
   - Stimulus: mm2reg=1, mwreg=1, malu=0x100, mrn=5, d_ack=1 and d_rdata=0xDEADBEEF in the same cycle.
   - Required: mem_stall=0 throughout; next edge gives wmo=0xDEADBEEF, walu=0x100, wrn=5, wwreg=1, wm2reg=1.
3. Store with 3 wait states:
   - Stimulus: mwmem=1, malu=0x40, mb=0x12345678, d_ack on the 4th cycle.
   - Required: d_req, d_we, d_addr and d_wdata stable for 4 cycles; mem_stall=1 for 3 cycles; bubbles in W for those cycles; then wwreg=mwreg.
4. Timeout:
   - Stimulus: TIMEOUT=3, load with d_ack never asserted.
   - Required: mem_stall=1 for 3 cycles, then 0; W gets wwreg=0, wmo=0; bus_err pulses 1 cycle; FSM returns to IDLE.
5. Back-to-back:
   - Stimulus: ALU op (access=0, walu=7), then load acked after 1 wait.
   - Required: ALU result in W after 1 cycle; one bubble; load result in W 2 cycles after the load enters.
6. MEM_ALIGN_CHECK_EN:
   - Stimulus: load at malu=0x102.
   - Required: d_req stays 0, mexc pulses 1 cycle, wwreg=0.

Source files
------------

// File: rtl/pipe_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory system (slave).
//
// Handshake: the master holds d_req=1 with d_we/d_addr/d_wdata stable until it
// samples d_ack=1 on a rising edge; d_ack is a single-cycle pulse and d_rdata is
// only meaningful in that cycle. When d_req=0 the master drives d_we, d_addr and
// d_wdata to 0, and any d_ack seen then carries no meaning.
interface pipe_mem_stage_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    input  d_ack,
    input  d_rdata
  );

  modport slave (
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    output d_ack,
    output d_rdata
  );
endinterface

// File: rtl/pipe_mem_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Issues the data-memory load/store over a req/ack bus, stalls the upstream
// pipeline while the access is outstanding, abandons it after TIMEOUT wait
// cycles (bus_err pulse) and registers the results toward WB.
// Optional: define MEM_ALIGN_CHECK_EN to add the mexc output; misaligned
// accesses (malu[1:0] != 0) are then dropped as a bubble and flagged on mexc.
// fsm_state exposes the FSM (0 = IDLE, 1 = BUSY) for observation.
module pipe_mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  input  logic [4:0]       mrn,
  pipe_mem_stage_if.master bus,
  output logic             mem_stall,
  output logic             bus_err,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [31:0]      wmo,
  output logic [31:0]      walu,
  output logic [4:0]       wrn,
  output logic             fsm_state
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic             mexc
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic access;       // instruction in MEM touches memory
  logic misalign;     // access dropped by the alignment check
  logic bus_access;   // access that actually goes onto the bus
  logic req;          // d_req, forced low while in reset
  logic timeout_hit;  // final wait cycle expired without an ack
  logic stall_raw;    // waiting on the bus this cycle
  logic bubble;       // MEM/WB loads all zeros this cycle
  logic take_data;    // load completes this cycle, latch d_rdata

  // Classify the instruction currently in MEM.
  always_comb begin
    access   = mm2reg | mwmem;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = access & (malu[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    bus_access = access & ~misalign;
    req        = bus_access & clrn;
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE enters BUSY only when the first cycle goes unacked;
  // BUSY leaves on ack or when the counter has reached TIMEOUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus_access && !bus.d_ack) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        if (!bus_access || bus.d_ack || (cnt_q >= CNT_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: bus drive, stall and MEM/WB load controls. An ack always
  // wins over the timeout in the same cycle.
  always_comb begin
    timeout_hit = (state_q == BUSY) && bus_access && !bus.d_ack && (cnt_q >= CNT_MAX);
    stall_raw   = bus_access && !bus.d_ack && !timeout_hit;
    bubble      = stall_raw || misalign;
    take_data   = bus_access && bus.d_ack && mm2reg && !mwmem;
    mem_stall   = stall_raw && clrn;

    bus.d_req   = req;
    bus.d_we    = req & mwmem;
    bus.d_addr  = req ? malu : 32'h0;
    bus.d_wdata = req ? mb   : 32'h0;

    fsm_state   = state_q;
  end

  // MEM/WB pipeline register and the registered error pulse(s).
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wwreg   <= 1'b0;
      wm2reg  <= 1'b0;
      wmo     <= 32'h0;
      walu    <= 32'h0;
      wrn     <= 5'h0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_hit;
      if (bubble) begin
        wwreg  <= 1'b0;
        wm2reg <= 1'b0;
        wmo    <= 32'h0;
        walu   <= 32'h0;
        wrn    <= 5'h0;
      end else begin
        // A timed-out access still retires, but must not write the register file.
        wwreg  <= mwreg & ~timeout_hit;
        wm2reg <= mm2reg;
        wmo    <= take_data ? bus.d_rdata : 32'h0;
        walu   <= malu;
        wrn    <= mrn;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle exception pulse following a dropped misaligned access.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mexc <= 1'b0;
    end else begin
      mexc <= misalign;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage (TIMEOUT=3).
// Directed vectors are applied on the falling edge; the expected MEM/WB
// contents after the following rising edge are queued and a separate monitor
// compares them. Builds with or without MEM_ALIGN_CHECK_EN.
module tb_pipe_mem_stage;

  localparam int W = 73;

  logic        clk;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mem_stall, bus_err, wwreg, wm2reg, fsm_state;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
  logic        mexc_act;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  pipe_mem_stage_if bus ();

`ifdef MEM_ALIGN_CHECK_EN
  logic mexc;
  assign mexc_act = mexc;
`else
  assign mexc_act = 1'b0;
`endif

  pipe_mem_stage #(.TIMEOUT(3)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .mrn       (mrn),
    .bus       (bus),
    .mem_stall (mem_stall),
    .bus_err   (bus_err),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wmo       (wmo),
    .walu      (walu),
    .wrn       (wrn),
    .fsm_state (fsm_state)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mexc      (mexc)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // {mexc, bus_err, wwreg, wm2reg, wmo, walu, wrn}
  function automatic logic [W-1:0] wv(logic wreg, logic m2reg, logic [31:0] mo,
                                      logic [31:0] alu, logic [4:0] rn,
                                      logic err, logic ex);
    return {ex, err, wreg, m2reg, mo, alu, rn};
  endfunction

  function automatic logic [W-1:0] w_act();
    return {mexc_act, bus_err, wwreg, wm2reg, wmo, walu, wrn};
  endfunction

  // Monitor: MEM/WB presents a new value after every rising edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) chk("w_regs", w_act(), exp_q.pop_front());
  end

  // Driver: apply one EX/MEM + bus-response vector for one cycle.
  task automatic step(input logic wreg, input logic m2reg, input logic wmem,
                      input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                      input logic ack, input logic [31:0] rdata,
                      input logic exp_stall, input logic exp_req,
                      input logic [W-1:0] exp_w);
    @(negedge clk);
    mwreg = wreg; mm2reg = m2reg; mwmem = wmem;
    malu = alu; mb = b; mrn = rn;
    bus.d_ack = ack; bus.d_rdata = rdata;
    #1;
    chk("mem_stall", W'(mem_stall), W'(exp_stall));
    chk("d_req",     W'(bus.d_req), W'(exp_req));
    chk("d_we",      W'(bus.d_we),  W'(exp_req & wmem));
    chk("d_addr",    W'(bus.d_addr),  exp_req ? W'(alu) : '0);
    chk("d_wdata",   W'(bus.d_wdata), exp_req ? W'(b)   : '0);
    exp_q.push_back(exp_w);
  endtask

  initial begin
    clrn = 1'b0;
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0;
    malu = 32'h100; mb = 32'h0; mrn = 5'd5;
    bus.d_ack = 1'b0; bus.d_rdata = 32'h0;

    // Reset state: a pending load must not raise a request while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_w",     w_act(), '0);
    chk("rst_req",   W'(bus.d_req), '0);
    chk("rst_stall", W'(mem_stall), '0);
    chk("rst_fsm",   W'(fsm_state), '0);
    clrn = 1'b1;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0; malu = 32'h0;

    // Zero-wait load
    step(1, 1, 0, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF, 0, 1,
         wv(1, 1, 32'hDEADBEEF, 32'h100, 5'd5, 0, 0));

    // Store with 3 wait states, ack on the 4th cycle (rdata must be ignored)
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 32'h40, 32'h12345678, 5'd3, 0, 32'h0, 1, 1, '0);
    step(1, 0, 1, 32'h40, 32'h12345678, 5'd3, 1, 32'hAAAA5555, 0, 1,
         wv(1, 0, 32'h0, 32'h40, 5'd3, 0, 0));

    // Timeout: load never acked
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 32'h80, 32'h0, 5'd7, 0, 32'h0, 1, 1, '0);
    step(1, 1, 0, 32'h80, 32'h0, 5'd7, 0, 32'h0, 0, 1,
         wv(0, 1, 32'h0, 32'h80, 5'd7, 1, 0));

    // Back-to-back: ALU op (stray ack ignored), then load acked after one wait
    step(1, 0, 0, 32'h7, 32'h0, 5'd9, 1, 32'hFFFFFFFF, 0, 0,
         wv(1, 0, 32'h0, 32'h7, 5'd9, 0, 0));
    step(1, 1, 0, 32'h200, 32'h0, 5'd10, 0, 32'h0, 1, 1, '0);
    step(1, 1, 0, 32'h200, 32'h0, 5'd10, 1, 32'h00000055, 0, 1,
         wv(1, 1, 32'h55, 32'h200, 5'd10, 0, 0));

    // Load and store both set: treated as a store, wm2reg still passed through
    step(1, 1, 1, 32'h300, 32'h0000CAFE, 5'd6, 1, 32'h11111111, 0, 1,
         wv(1, 1, 32'h0, 32'h300, 5'd6, 0, 0));

    // Misaligned load at 0x102
`ifdef MEM_ALIGN_CHECK_EN
    step(1, 1, 0, 32'h102, 32'h0, 5'd4, 1, 32'h0BADF00D, 0, 0,
         wv(0, 0, 32'h0, 32'h0, 5'd0, 0, 1));
`else
    step(1, 1, 0, 32'h102, 32'h0, 5'd4, 1, 32'h0BADF00D, 0, 1,
         wv(1, 1, 32'h0BADF00D, 32'h102, 5'd4, 0, 0));
`endif
    // Idle cycle: mexc / bus_err back to 0
    step(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0, '0);

    // Reset mid-BUSY: load unacked for 2 cycles, then reset
    step(1, 1, 0, 32'h500, 32'h0, 5'd12, 0, 32'h0, 1, 1, '0);
    step(1, 1, 0, 32'h500, 32'h0, 5'd12, 0, 32'h0, 1, 1, '0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_w",     w_act(), '0);
    chk("midrst_req",   W'(bus.d_req), '0);
    chk("midrst_stall", W'(mem_stall), '0);
    chk("midrst_fsm",   W'(fsm_state), '0);
    @(posedge clk); #1;
    chk("midrst_w_edge", w_act(), '0);
    @(negedge clk);
    clrn = 1'b1;
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0; malu = 32'h0; mrn = 5'd0;
    #1;
    chk("post_rst_req", W'(bus.d_req), '0);
    @(posedge clk); #1;
    chk("post_rst_fsm", W'(fsm_state), '0);

    // After reset the stage is IDLE: a zero-wait load completes in one cycle
    step(1, 1, 0, 32'h600, 32'h0, 5'd2, 1, 32'h76543210, 0, 1,
         wv(1, 1, 32'h76543210, 32'h600, 5'd2, 0, 0));

    repeat (2) @(posedge clk);
    #2;
    chk("drain", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
